// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle CPU control FSM with memory handshake, wait-state timeout and sticky trap.
// Define MC_CTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module mc_ctrl_fsm #(
   parameter int WAIT_LIMIT = 16,
   parameter int WAIT_CNT_W = 8
`ifdef MC_CTRL_PERF_EN
   ,parameter int CNT_W = 32
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic [5:0]       Funct,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemWrite,
   output logic             MemRead,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ExtOp,
   output logic             LuiOp,
   output logic             PCorData,
   output logic [1:0]       RegDst,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic [3:0]       ALUOp,
   output logic             cond_inv,
   output logic             trap,
   output logic [1:0]       trap_cause
`ifdef MC_CTRL_PERF_EN
   ,output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
`endif
);
   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_write;
      logic       mem_read;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       ext_op;
      logic       lui_op;
      logic       pc_or_data;
      logic [1:0] reg_dst;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [3:0] alu_op;
      logic       cond_inv;
   } ctl_t;
   localparam logic [WAIT_CNT_W-1:0] LIM_M1 = WAIT_CNT_W'(WAIT_LIMIT - 1);
   state_t                state, nxt;
   ctl_t                  ctl;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  is_r, is_lw, is_jr, is_shift, legal, mem_state, timeout;
   assign is_r      = Opcode == 6'h00;
   assign is_lw     = Opcode == 6'h23;
   assign is_jr     = Funct == 6'h08;
   assign is_shift  = Funct inside {6'h00, 6'h02, 6'h03};
   assign legal     = is_r ? Funct inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B}
                           : Opcode inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                            6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
   assign mem_state = state == S_IF || state == S_MEM;
   // the stall cycle that would make WAIT_LIMIT consecutive waits; mem_ready in that cycle wins
   assign timeout   = WAIT_LIMIT != 0 && mem_state && !mem_ready && wait_cnt == LIM_M1;
   always_comb begin
      ctl = '0;
      nxt = state;
      case (state)
         S_IF: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'b01;
            ctl.ir_write  = mem_ready;
            ctl.pc_write  = mem_ready;
            nxt           = mem_ready ? S_ID : timeout ? S_TRAP : S_IF;
         end
         S_ID: begin
            ctl.alu_src_b = 2'b11;
            ctl.ext_op    = 1'b1;
            nxt           = legal ? S_EX : S_TRAP;
         end
         S_EX: case (Opcode)
            6'h00: begin
               ctl.alu_src_a = is_shift ? 2'b10 : 2'b01;
               ctl.alu_op    = is_jr ? 4'b0111 : 4'b0010;
               ctl.pc_write  = is_jr;
               nxt           = is_jr ? S_IF : S_WB;
            end
            6'h23, 6'h2B: begin
               ctl.alu_src_a = 2'b01;
               ctl.alu_src_b = 2'b10;
               ctl.ext_op    = 1'b1;
               nxt           = S_MEM;
            end
            6'h04, 6'h05: begin
               ctl.alu_src_a     = 2'b01;
               ctl.alu_op        = 4'b0001;
               ctl.pc_write_cond = 1'b1;
               ctl.pc_source     = 2'b01;
               ctl.cond_inv      = Opcode[0];
               nxt               = S_IF;
            end
            6'h02, 6'h03: begin
               ctl.pc_write   = 1'b1;
               ctl.pc_source  = 2'b11;
               ctl.reg_dst    = Opcode[0] ? 2'b10 : 2'b00;
               ctl.pc_or_data = Opcode[0];
               ctl.reg_write  = Opcode[0];
               nxt            = S_IF;
            end
            default: begin
               // immediate ALU ops: 08..0B sign-extend, 0C/0D zero-extend, 0F lui
               ctl.alu_src_a = 2'b01;
               ctl.alu_src_b = 2'b10;
               ctl.ext_op    = !Opcode[2];
               ctl.lui_op    = Opcode == 6'h0F;
               ctl.alu_op    = Opcode[2:0] == 3'b010 ? 4'b0101 :
                               Opcode[2:0] == 3'b011 ? 4'b0110 :
                               Opcode[2:0] == 3'b100 ? 4'b0011 :
                               Opcode[2:0] == 3'b101 ? 4'b0100 : 4'b0000;
               nxt           = S_WB;
            end
         endcase
         S_MEM: begin
            ctl.iord      = 1'b1;
            ctl.mem_read  = is_lw;
            ctl.mem_write = !is_lw;
            nxt           = mem_ready ? (is_lw ? S_WB : S_IF) : timeout ? S_TRAP : S_MEM;
         end
         S_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = is_r ? 2'b01 : 2'b00;
            ctl.mem_to_reg = is_lw;
            nxt            = S_IF;
         end
         default: nxt = S_TRAP;
      endcase
      if (reset) ctl = '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IF;
         wait_cnt   <= '0;
         trap_cause <= 2'b00;
      end else begin
         state    <= nxt;
         wait_cnt <= (nxt != state || mem_ready || !mem_state) ? '0 : wait_cnt + WAIT_CNT_W'(1);
         if (state != S_TRAP && nxt == S_TRAP) trap_cause <= state == S_ID ? 2'b01 : 2'b10;
      end
   end
   assign trap = state == S_TRAP;
   assign {PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, MemtoReg, RegWrite, ExtOp, LuiOp,
           PCorData, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, cond_inv} = ctl;
`ifdef MC_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (state != S_IF && nxt == S_IF) instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: cycle-by-cycle scoreboard bench for mc_ctrl_fsm (WAIT_LIMIT=4).
// Build with MC_CTRL_PERF_EN to also check the performance counters.
module tb_mc_ctrl_fsm;
   logic clk = 1'b0;
   logic reset, mem_ready;
   logic [5:0] Opcode, Funct;
   logic PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, MemtoReg, RegWrite;
   logic ExtOp, LuiOp, PCorData, cond_inv, trap;
   logic [1:0] RegDst, ALUSrcA, ALUSrcB, PCSource, trap_cause;
   logic [3:0] ALUOp;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif
   mc_ctrl_fsm #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
      .MemRead(MemRead), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ExtOp(ExtOp), .LuiOp(LuiOp), .PCorData(PCorData), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .cond_inv(cond_inv),
      .trap(trap), .trap_cause(trap_cause)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );
   always #5 clk = ~clk;
   // {PCWrite,PCWriteCond,IorD,MemWrite,MemRead,IRWrite,MemtoReg,RegWrite,ExtOp,LuiOp,PCorData,
   //  RegDst[15:14],ALUSrcA[13:12],ALUSrcB[11:10],PCSource[9:8],ALUOp[7:4],cond_inv,trap,trap_cause}
   logic [26:0] vec;
   assign vec = {PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, MemtoReg, RegWrite, ExtOp,
                 LuiOp, PCorData, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, cond_inv, trap, trap_cause};
   localparam logic [26:0] PCW = 27'd1 << 26, PCWC = 27'd1 << 25, IORD = 27'd1 << 24, MW = 27'd1 << 23;
   localparam logic [26:0] MR = 27'd1 << 22, IRW = 27'd1 << 21, MTR = 27'd1 << 20, RW = 27'd1 << 19;
   localparam logic [26:0] EXT = 27'd1 << 18, POD = 27'd1 << 16, CI = 27'd1 << 3, TRP = 27'd1 << 2;
   localparam logic [26:0] IFW    = MR | (27'd1 << 10);
   localparam logic [26:0] IFR    = IFW | IRW | PCW;
   localparam logic [26:0] IDV    = (27'd3 << 10) | EXT;
   localparam logic [26:0] EX_R   = (27'd1 << 12) | (27'd2 << 4);
   localparam logic [26:0] EX_SH  = (27'd2 << 12) | (27'd2 << 4);
   localparam logic [26:0] EX_M   = (27'd1 << 12) | (27'd2 << 10) | EXT;
   localparam logic [26:0] EX_BEQ = (27'd1 << 12) | (27'd1 << 4) | PCWC | (27'd1 << 8);
   localparam logic [26:0] EX_BNE = EX_BEQ | CI;
   localparam logic [26:0] EX_J   = PCW | (27'd3 << 8);
   localparam logic [26:0] EX_JAL = EX_J | (27'd2 << 14) | POD | RW;
   localparam logic [26:0] EX_JR  = (27'd1 << 12) | (27'd7 << 4) | PCW;
   localparam logic [26:0] EX_ORI = (27'd1 << 12) | (27'd2 << 10) | (27'd4 << 4);
   localparam logic [26:0] EX_SLT = (27'd1 << 12) | (27'd2 << 10) | (27'd5 << 4) | EXT;
   localparam logic [26:0] M_LW   = IORD | MR;
   localparam logic [26:0] M_SW   = IORD | MW;
   localparam logic [26:0] WB_R   = RW | (27'd1 << 14);
   localparam logic [26:0] WB_I   = RW;
   localparam logic [26:0] WB_LW  = RW | MTR;
   localparam logic [26:0] T1     = TRP | 27'd1;
   localparam logic [26:0] T2     = TRP | 27'd2;
   typedef struct {
      string       nm;
      logic [26:0] v;
   } exp_t;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", nm, act, want, $time);
      end
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk(e.nm, 64'(vec), 64'(e.v));
      end
   end
   task automatic step(input logic mr, input logic [26:0] e, input string nm, input bit en = 1'b1);
      mem_ready = mr;
      if (en) q.push_back('{nm, e});
      @(posedge clk);
      #1;
   endtask
   task automatic instr(input logic [5:0] op, input logic [5:0] fn);
      Opcode = op;
      Funct  = fn;
   endtask
   task automatic fetch(input int stalls);
      for (int i = 0; i < stalls; i++) step(1'b0, IFW, "if_wait");
      step(1'b1, IFR, "if_fetch");
   endtask
   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 27'd0, "", 1'b0);
      reset = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1;
      mem_ready = 1'b0;
      instr(6'h00, 6'h20);
      @(posedge clk);
      #1;
      step(1'b1, 27'd0, "reset_forces_zero");
      reset = 1'b0;
      // add: 4 cycles
      fetch(0); step(1'b0, IDV, "add_id"); step(1'b0, EX_R, "add_ex"); step(1'b0, WB_R, "add_wb");
`ifdef MC_CTRL_PERF_EN
      chk("instret_after_add", 64'(instret_cnt), 64'd1);
      chk("cycles_after_add", 64'(cycle_cnt), 64'd4);
`endif
      // lw: 3 fetch stalls, 2 memory stalls, 10 cycles
      instr(6'h23, 6'h3F);
      fetch(3); step(1'b0, IDV, "lw_id"); step(1'b0, EX_M, "lw_ex");
      step(1'b0, M_LW, "lw_mem_wait"); step(1'b0, M_LW, "lw_mem_wait"); step(1'b1, M_LW, "lw_mem_done");
      step(1'b0, WB_LW, "lw_wb");
      // sw zero-wait
      instr(6'h2B, 6'h00);
      fetch(0); step(1'b0, IDV, "sw_id"); step(1'b0, EX_M, "sw_ex"); step(1'b1, M_SW, "sw_mem");
      // bne / beq, mem_ready high outside memory states is ignored
      instr(6'h05, 6'h00);
      fetch(0); step(1'b1, IDV, "bne_id"); step(1'b1, EX_BNE, "bne_ex");
      instr(6'h04, 6'h00);
      fetch(0); step(1'b0, IDV, "beq_id"); step(1'b0, EX_BEQ, "beq_ex");
      instr(6'h02, 6'h00);
      fetch(0); step(1'b0, IDV, "j_id"); step(1'b0, EX_J, "j_ex");
      instr(6'h03, 6'h00);
      fetch(0); step(1'b0, IDV, "jal_id"); step(1'b0, EX_JAL, "jal_ex");
      instr(6'h00, 6'h08);
      fetch(0); step(1'b0, IDV, "jr_id"); step(1'b0, EX_JR, "jr_ex");
      instr(6'h00, 6'h00);
      fetch(0); step(1'b0, IDV, "sll_id"); step(1'b0, EX_SH, "sll_ex"); step(1'b0, WB_R, "sll_wb");
      instr(6'h0D, 6'h00);
      fetch(0); step(1'b0, IDV, "ori_id"); step(1'b0, EX_ORI, "ori_ex"); step(1'b0, WB_I, "ori_wb");
      instr(6'h0A, 6'h00);
      fetch(0); step(1'b0, IDV, "slti_id"); step(1'b0, EX_SLT, "slti_ex"); step(1'b0, WB_I, "slti_wb");
      // illegal opcode: sticky trap for 20 cycles, then reset
      instr(6'h3F, 6'h00);
      fetch(0); step(1'b0, IDV, "ill_id");
      for (int i = 0; i < 20; i++) step(1'(i % 3 == 0), T1, "trap_illegal_op");
      do_reset();
      instr(6'h00, 6'h20);
      fetch(1); step(1'b0, IDV, "post_trap_id"); step(1'b0, EX_R, "post_trap_ex"); step(1'b0, WB_R, "post_trap_wb");
      // illegal funct
      instr(6'h00, 6'h01);
      fetch(0); step(1'b0, IDV, "illf_id"); step(1'b0, T1, "trap_illegal_funct"); step(1'b1, T1, "trap_illegal_funct");
      do_reset();
      // fetch timeout after 4 stalls
      for (int i = 0; i < 4; i++) step(1'b0, IFW, "if_stall");
      step(1'b0, T2, "trap_timeout_if"); step(1'b1, T2, "trap_timeout_if");
      do_reset();
      // ready on the 4th cycle: no trap
      instr(6'h00, 6'h20);
      fetch(3); step(1'b0, IDV, "edge_id"); step(1'b0, EX_R, "edge_ex"); step(1'b0, WB_R, "edge_wb");
      // memory-state timeout on sw
      instr(6'h2B, 6'h00);
      fetch(0); step(1'b0, IDV, "swto_id"); step(1'b0, EX_M, "swto_ex");
      for (int i = 0; i < 4; i++) step(1'b0, M_SW, "swto_mem_wait");
      step(1'b0, T2, "trap_timeout_mem");
      do_reset();
      // reset in the middle of a sw access
      fetch(0); step(1'b0, IDV, "swr_id"); step(1'b0, EX_M, "swr_ex"); step(1'b0, M_SW, "swr_mem_wait");
      reset = 1'b1;
      step(1'b1, 27'd0, "reset_in_mem");
      reset = 1'b0;
`ifdef MC_CTRL_PERF_EN
      chk("instret_after_reset", 64'(instret_cnt), 64'd0);
      chk("cycles_after_reset", 64'(cycle_cnt), 64'd0);
`endif
      step(1'b1, IFR, "if_after_mem_reset");
      step(1'b0, IDV, "id_after_mem_reset");
      chk("queue_drain", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle CPU control unit, successor to the fixed-timing controller. Sequences IF/ID/EX/MEM/WB and drives the same datapath control vector (PCWrite … PCorData). Adds a variable-latency memory handshake, a bounded wait-state timeout, `bne` and `jr` support, and a sticky trap state for illegal opcodes and timeouts. Sits between the instruction register (Opcode/Funct) and the datapath muxes, ALU control, PC and memory.

## Interface
- `WAIT_LIMIT`, 16: max consecutive wait cycles per memory access before trapping; 0 disables timeout.
- `WAIT_CNT_W`, 8: width of the wait counter; must satisfy WAIT_LIMIT < 2^WAIT_CNT_W.
- `CNT_W`, 32: width of perf counters (only with `MC_CTRL_PERF_EN`).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `Opcode` / `Funct`  in  6 / 6  from instruction register.
- `mem_ready`  in  1  memory completes the current MemRead/MemWrite this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemWrite`, `MemRead`, `IRWrite`, `MemtoReg`, `RegWrite`, `ExtOp`, `LuiOp`, `PCorData`  out  1 each  datapath controls.
- `RegDst`, `ALUSrcA`, `ALUSrcB`, `PCSource`  out  2 each  mux selects; encodings unchanged from current datapath.
- `ALUOp`  out  4  0000 add, 0001 sub, 0010 R-type (use Funct), 0011 and, 0100 or, 0101 slt, 0110 sltu, 0111 pass In1.
- `cond_inv`  out  1  invert Zero in PC write condition (bne).
- `trap`  out  1  sticky; core halted.
- `trap_cause`  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout.
- `cycle_cnt`, `instret_cnt`  out  CNT_W  perf counters (only with `MC_CTRL_PERF_EN`).

## Operation
- States: IF, ID, EX, MEM, WB, TRAP. Outputs are Moore-decoded from state plus latched Opcode/Funct, except handshake-qualified strobes noted below.
- IF: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00. IRWrite and PCWrite assert only in the cycle `mem_ready`=1; then → ID. Otherwise stay in IF.
- ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=add (branch target into ALUout). Decode: illegal → TRAP cause 01; else → EX.
- EX per instruction:
  - R-type: ALUSrcA=01 (10 for funct 00/02/03 shifts), ALUSrcB=00, ALUOp=0010 → WB.
  - jr (funct 08): ALUSrcA=01, ALUOp=0111, PCSource=00, PCWrite → IF.
  - lw/sw: ALUSrcA=01, ALUSrcB=10, ExtOp=1, add → MEM.
  - beq/bne: ALUSrcA=01, ALUSrcB=00, sub, PCWriteCond=1, PCSource=01, cond_inv = (op==05) → IF.
  - j: PCSource=11, PCWrite → IF. jal: also RegDst=10, PCorData=1, RegWrite → IF.
  - addi/addiu/slti/sltiu (ExtOp=1), andi/ori (ExtOp=0), lui (LuiOp=1): ALUSrcA=01, ALUSrcB=10, matching ALUOp → WB.
- MEM: IorD=1; lw MemRead=1, sw MemWrite=1; held until `mem_ready`. lw → WB, sw → IF.
- WB: RegWrite=1; R-type RegDst=01, MemtoReg=0; I-type RegDst=00, MemtoReg=0; lw RegDst=00, MemtoReg=1 → IF.
- Legal opcodes: 00,02,03,04,05,08,09,0A,0B,0C,0D,0F,23,2B. Legal R funct: 00,02,03,08,20–27,2A,2B. All else illegal.
- Wait counter: clears on entry to IF/MEM and on `mem_ready`; increments each stalled cycle; reaching WAIT_LIMIT (WAIT_LIMIT>0) → TRAP cause 10 next edge, no strobe issued.
- TRAP: all controls 0, `trap`=1, stays until reset.

## Timing
- Reset (synchronous): next edge state=IF, wait counter 0, trap=0, trap_cause=00, perf counters 0. While `reset`=1 all control outputs forced 0. Reset mid-access abandons it; no IRWrite/PCWrite/RegWrite issued.
- Zero-wait cycles: R-type/I-type 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3. Each memory state adds one cycle per cycle of `mem_ready`=0.
- `mem_ready` in a non-memory state is ignored.
- Timeout and `mem_ready` in the same cycle: `mem_ready` wins.

## Configuration
- `MC_CTRL_PERF_EN` defined: `cycle_cnt` increments every non-reset cycle outside TRAP; `instret_cnt` increments on the last state of each instruction (transition to IF). Both wrap at 2^CNT_W.
- Undefined: ports and counters absent; no other behaviour change.

## Test plan
- Reset, then `add` (op 00, funct 20) with `mem_ready`=1 → IF,ID,EX,WB in 4 cycles; WB has RegWrite=1, RegDst=01; instret_cnt=1.
- `lw` (op 23), `mem_ready` low 3 cycles in IF and 2 in MEM → 10 cycles total; IRWrite exactly one pulse; WB MemtoReg=1.
- `bne` (op 05) → EX has PCWriteCond=1, cond_inv=1, PCSource=01; back in IF at cycle 3.
- Opcode 3F → TRAP after ID, trap_cause=01, all controls 0 for 20 further cycles; reset clears to IF.
- WAIT_LIMIT=4, `mem_ready` held 0 in IF → trap_cause=10 after 4 stall cycles; repeat with `mem_ready`=1 on the 4th cycle → no trap.
- Assert reset during MEM of `sw` → MemWrite=0 at that edge, IF next cycle, counters 0.
